// File: rtl/dds_sweep_ctrl_if.sv
// Control/status bundle between the register bank, the sweep scheduler and the DDS.
interface dds_sweep_ctrl_if #(
  parameter int DWELL_W = 16
);
  logic               start;
  logic               abort;
  logic [1:0]         mode;
  logic [31:0]        start_step;
  logic [31:0]        stop_step;
  logic [31:0]        delta_step;
  logic [DWELL_W-1:0] dwell;
  logic [31:0]        step;
  logic               busy;
  logic               point_strobe;
  logic               done;
  logic               err;

  modport master (
    output start, abort, mode, start_step, stop_step, delta_step, dwell,
    input  step, busy, point_strobe, done, err
  );

  modport slave (
    input  start, abort, mode, start_step, stop_step, delta_step, dwell,
    output step, busy, point_strobe, done, err
  );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep scheduler driving the DDS step word.
// Modes: single, repeating sawtooth, triangle. step is held at 0 while idle.
module dds_sweep_ctrl #(
  parameter int DWELL_W = 16
) (
  input  logic              clk,
  input  logic              resetn,
  dds_sweep_ctrl_if.slave   bus
);
  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [1:0] MODE_REP = 2'd1;
  localparam logic [1:0] MODE_TRI = 2'd2;

  state_t             state_q;
  logic               dir_q;         // 0 = ascending, 1 = descending
  logic [31:0]        step_q;
  logic               busy_q, strobe_q, done_q, err_q;
  logic [DWELL_W-1:0] cnt_q, reload_q;
  logic [1:0]         mode_q;
  logic [31:0]        start_q, stop_q, delta_q;

  // Advance decision for the point after the current one.
  logic [31:0] nxt_d;
  logic        dir_d, done_d, stop_d;
  logic [32:0] cand;
  logic [31:0] diff;
  logic        can_down;

  logic [DWELL_W-1:0] reload_in;
  logic               cfg_bad;

  assign reload_in = (bus.dwell == '0) ? '0 : bus.dwell - 1'b1;
  assign cfg_bad   = (bus.delta_step == 32'd0) || (bus.start_step > bus.stop_step);

  assign cand     = {1'b0, step_q} + {1'b0, delta_q};
  assign diff     = step_q - start_q;
  assign can_down = (diff >= delta_q);

  // Next sweep point: descend while room remains, otherwise climb; top handled per mode.
  always_comb begin
    nxt_d  = step_q;
    dir_d  = dir_q;
    done_d = 1'b0;
    stop_d = 1'b0;
    if (dir_q && can_down) begin
      nxt_d = step_q - delta_q;
    end else if (cand <= {1'b0, stop_q}) begin
      nxt_d = cand[31:0];
      dir_d = 1'b0;
    end else begin
      case (mode_q)
        MODE_REP: begin
          nxt_d  = start_q;
          dir_d  = 1'b0;
          done_d = 1'b1;
        end
        MODE_TRI: begin
          dir_d = 1'b1;
          nxt_d = can_down ? step_q - delta_q : start_q;
        end
        default: stop_d = 1'b1;
      endcase
    end
    // Triangle completes a cycle whenever the bottom point is re-presented.
    if (mode_q == MODE_TRI && !stop_d && nxt_d == start_q)
      done_d = 1'b1;
  end

  // Sweep FSM; all outputs registered, pulses default low every cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      dir_q    <= 1'b0;
      step_q   <= '0;
      busy_q   <= 1'b0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      reload_q <= '0;
      mode_q   <= '0;
      start_q  <= '0;
      stop_q   <= '0;
      delta_q  <= '0;
    end else begin
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      if (bus.abort) begin
        state_q <= IDLE;
        step_q  <= '0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.start) begin
              if (cfg_bad) begin
                err_q <= 1'b1;
              end else begin
                mode_q   <= bus.mode;
                start_q  <= bus.start_step;
                stop_q   <= bus.stop_step;
                delta_q  <= bus.delta_step;
                reload_q <= reload_in;
                cnt_q    <= reload_in;
                step_q   <= bus.start_step;
                dir_q    <= 1'b0;
                strobe_q <= 1'b1;
                busy_q   <= 1'b1;
                state_q  <= RUN;
              end
            end
          end
          RUN: begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - 1'b1;
            end else if (stop_d) begin
              state_q <= IDLE;
              step_q  <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              step_q   <= nxt_d;
              dir_q    <= dir_d;
              done_q   <= done_d;
              strobe_q <= 1'b1;
              cnt_q    <= reload_q;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.step         = step_q;
  assign bus.busy         = busy_q;
  assign bus.point_strobe = strobe_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_dds_sweep_ctrl;
  localparam int DWELL_W = 16;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  dds_sweep_ctrl_if #(.DWELL_W(DWELL_W)) bus ();

  dds_sweep_ctrl #(.DWELL_W(DWELL_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    int          cyc;
    logic [31:0] step;
    logic        busy;
    logic        ps;
    logic        done;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   cyc_cnt = 0;
  int   checks  = 0;
  int   errors  = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor: one expected snapshot per clock edge, compared mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (e.cyc != cyc_cnt || bus.step !== e.step || bus.busy !== e.busy ||
          bus.point_strobe !== e.ps || bus.done !== e.done || bus.err !== e.err) begin
        errors++;
        $display("FAIL cycle%0d: got step=%h busy=%b ps=%b done=%b err=%b, want step=%h busy=%b ps=%b done=%b err=%b (tag %0d)",
                 cyc_cnt, bus.step, bus.busy, bus.point_strobe, bus.done, bus.err,
                 e.step, e.busy, e.ps, e.done, e.err, e.cyc);
      end
    end
  end

  task automatic cfg(input logic [1:0] m, input logic [31:0] s0, s1, d,
                     input logic [DWELL_W-1:0] dw);
    bus.mode = m; bus.start_step = s0; bus.stop_step = s1;
    bus.delta_step = d; bus.dwell = dw;
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic tick(input logic st, ab, input logic [31:0] s,
                      input logic b, p, d, e);
    exp_t x;
    bus.start = st;
    bus.abort = ab;
    x.cyc = cyc_cnt + 1; x.step = s; x.busy = b; x.ps = p; x.done = d; x.err = e;
    q.push_back(x);
    @(posedge clk); #1;
  endtask

  // One sweep point held for n cycles; strobe (and optional done) on its first cycle.
  task automatic pt(input logic st, input logic [31:0] v, input int n, input logic dn);
    for (int i = 0; i < n; i++)
      tick((i == 0) ? st : 1'b0, 1'b0, v, 1'b1, (i == 0), (i == 0) ? dn : 1'b0, 1'b0);
  endtask

  task automatic idle(input logic d);
    tick(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, d, 1'b0);
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0;
    cfg(2'd0, 32'd0, 32'd0, 32'd0, '0);
    @(posedge clk); #1;

    // Reset state
    resetn = 1'b0;
    idle(1'b0); idle(1'b0);
    resetn = 1'b1;
    idle(1'b0);

    // Single sweep 100..130 step 10, dwell 3
    cfg(2'd0, 32'd100, 32'd130, 32'd10, 16'd3);
    pt(1'b1, 32'd100, 3, 1'b0);
    pt(1'b0, 32'd110, 3, 1'b0);
    pt(1'b0, 32'd120, 3, 1'b0);
    pt(1'b0, 32'd130, 3, 1'b0);
    idle(1'b1); idle(1'b0);

    // Non-aligned top, dwell 0 behaves as 1; mode 3 behaves as single
    cfg(2'd3, 32'h10, 32'h35, 32'h10, 16'd0);
    pt(1'b1, 32'h10, 1, 1'b0);
    pt(1'b0, 32'h20, 1, 1'b0);
    pt(1'b0, 32'h30, 1, 1'b0);
    idle(1'b1); idle(1'b0);

    // Triangle 10..30 step 10, dwell 1, then abort
    cfg(2'd2, 32'd10, 32'd30, 32'd10, 16'd1);
    pt(1'b1, 32'd10, 1, 1'b0);
    pt(1'b0, 32'd20, 1, 1'b0);
    pt(1'b0, 32'd30, 1, 1'b0);
    pt(1'b0, 32'd20, 1, 1'b0);
    pt(1'b0, 32'd10, 1, 1'b1);
    pt(1'b0, 32'd20, 1, 1'b0);
    pt(1'b0, 32'd30, 1, 1'b0);
    pt(1'b0, 32'd20, 1, 1'b0);
    pt(1'b0, 32'd10, 1, 1'b1);
    tick(1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);

    // Repeat 5..7 step 1, dwell 2; config churn and start while busy are ignored
    cfg(2'd1, 32'd5, 32'd7, 32'd1, 16'd2);
    pt(1'b1, 32'd5, 2, 1'b0);
    pt(1'b0, 32'd6, 2, 1'b0);
    pt(1'b0, 32'd7, 2, 1'b0);
    cfg(2'd0, 32'd900, 32'd1000, 32'd50, 16'd7);
    pt(1'b0, 32'd5, 2, 1'b1);
    tick(1'b0, 1'b0, 32'd6, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 32'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    pt(1'b0, 32'd7, 2, 1'b0);
    pt(1'b0, 32'd5, 2, 1'b1);
    tick(1'b0, 1'b0, 32'd6, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);

    // Degenerate triangle: only start exists, re-presented each dwell with done
    cfg(2'd2, 32'd10, 32'd15, 32'd10, 16'd2);
    pt(1'b1, 32'd10, 2, 1'b0);
    pt(1'b0, 32'd10, 2, 1'b1);
    pt(1'b0, 32'd10, 2, 1'b1);
    tick(1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);

    // Rejections: zero delta, inverted range, start with abort
    cfg(2'd0, 32'd0, 32'd100, 32'd0, 16'd1);
    tick(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    cfg(2'd0, 32'd50, 32'd40, 32'd1, 16'd1);
    tick(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    cfg(2'd0, 32'd1, 32'd5, 32'd1, 16'd1);
    tick(1'b1, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);

    // 32-bit overflow on the first advance ends a single sweep after one point
    cfg(2'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h10, 16'd4);
    pt(1'b1, 32'hFFFF_FFF0, 4, 1'b0);
    idle(1'b1); idle(1'b0);

    // Reset mid-sweep: outputs clear with no done
    cfg(2'd0, 32'd100, 32'd130, 32'd10, 16'd3);
    pt(1'b1, 32'd100, 3, 1'b0);
    tick(1'b0, 1'b0, 32'd110, 1'b1, 1'b1, 1'b0, 1'b0);
    resetn = 1'b0;
    idle(1'b0);
    resetn = 1'b1;
    idle(1'b0); idle(1'b0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #6;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
Frequency-sweep scheduler for the phase-accumulator DDS. It drives the DDS 32-bit `step` word through a programmed linear sweep (single, repeating sawtooth, or triangle), holding each point for a programmable dwell.
- Sits between the control register bank and the DDS `step` input.
- Drives `step` = 0 whenever idle, which halts the DDS.

Parameters:
DWELL_W, 16, width of dwell count (cycles per sweep point)

Ports:
clk  in  1  system clock
resetn  in  1  synchronous reset, active-low
start  in  1  launch request; honoured only in IDLE
abort  in  1  stop sweep immediately
mode  in  2  0=single, 1=repeat sawtooth, 2=triangle, 3=treated as single
start_step  in  32  first (lowest) step value, unsigned
stop_step  in  32  upper bound, unsigned, inclusive
delta_step  in  32  increment per point, unsigned, nonzero
dwell  in  DWELL_W  cycles per point; 0 treated as 1
step  out  32  step word to DDS; 0 when idle
busy  out  1  sweep in progress
point_strobe  out  1  1-cycle pulse when step takes a new sweep point
done  out  1  1-cycle pulse at sweep completion / each cycle boundary
err  out  1  1-cycle pulse on rejected start

Behaviour:
- Reset (resetn=0 at a clk edge): state=IDLE, step=0, busy=0, point_strobe=0, done=0, err=0. Reset mid-sweep abandons the sweep with no done pulse.
- Configuration handling:
  - mode, start_step, stop_step, delta_step and dwell are latched on an accepted start.
  - Input changes while busy are ignored.
- States: IDLE, RUN (direction flag dir: 0=up, 1=down).
- IDLE, start=1, abort=0:
  - If delta_step==0 or start_step>stop_step: err=1 next cycle, stay IDLE.
  - Otherwise, next cycle: step=start_step, point_strobe=1, busy=1, dir=up, dwell counter loaded with dwell_eff-1 (dwell_eff = max(dwell,1)).
- RUN dwell:
  - Each point is held exactly dwell_eff cycles.
  - At counter==0, the next point is computed and presented on the following cycle with point_strobe=1, and the counter is reloaded.
- Up advance:
  - cand = cur + delta, computed in 33 bits.
  - If cand <= stop_step (no overflow): next = cand.
  - Otherwise the top is reached. The last point is the largest start+k*delta <= stop; no clamping to stop_step.
- Top reached, by mode:
  - single: step=0, busy=0, done=1 in the same cycle, go to IDLE.
  - repeat: next = start_step, done=1 coincident with that point_strobe.
  - triangle: dir=down. next = cur - delta if (cur - start_step) >= delta, else start_step. The top point is not repeated.
- Down advance (triangle only):
  - If (cur - start_step) >= delta: next = cur - delta.
  - Otherwise, or if cur==start_step: dir=up, next = cur + delta (subject to the up rules).
  - done=1 coincident with the point_strobe that re-presents start_step. The bottom point is not repeated.
- Degenerate range: if only one point exists (start==stop or delta > stop-start):
  - single: one dwell, then done.
  - repeat/triangle: start_step is re-presented every dwell_eff cycles with point_strobe=1 and done=1.
- abort=1 in any state: next cycle step=0, busy=0, state IDLE, no done pulse.
- abort and start in the same cycle: abort wins.
- start while busy: ignored.
- Outputs are registered; latency from start to the first step is 1 cycle.

Test Plan:
- Single sweep, start=100, stop=130, delta=10, dwell=3, start at cycle 0 → step=100 for cycles 1-3, 110 for 4-6, 120 for 7-9, 130 for 10-12. Cycle 13: step=0, busy=0, done=1. point_strobe at cycles 1, 4, 7, 10.
- Non-aligned range, start=0x10, stop=0x35, delta=0x10, dwell=0 → points 0x10, 0x20, 0x30, one cycle each; step=0 and done at cycle 4.
- Triangle, start=10, stop=30, delta=10, dwell=1 → step sequence 10, 20, 30, 20, 10, 20, 30, …; done=1 each time 10 is re-presented (cycle 5, 9, …); busy stays 1.
- Repeat, start=5, stop=7, delta=1, dwell=2 → 5, 5, 6, 6, 7, 7, 5, …; done coincident with each return to 5. Then abort at an arbitrary cycle → next cycle step=0, busy=0, no done.
- Rejections and priority:
  - delta_step=0 → err=1 one cycle later, busy stays 0, step stays 0.
  - start_step=50, stop_step=40 → same err response.
  - start and abort together in IDLE → nothing starts.
- Overflow and reset:
  - start=0xFFFF_FFF0, stop=0xFFFF_FFFF, delta=0x10, single, dwell=4 → exactly one point for 4 cycles, then done.
  - resetn=0 mid-sweep → step=0, busy=0, done=0 the next cycle.
